// File: rtl/spi_ram_pkg.sv
// Shared opcode encoding and default geometry for the SPI command memory.
// The SPI slave imports the same opcodes for its command decoding.
package spi_ram_pkg;

  localparam int DEF_ADDR_SIZE = 8;
  localparam int DEF_MEM_DEPTH = 256;

  typedef enum logic [1:0] {
    CMD_WR_ADDR = 2'b00,
    CMD_WR_DATA = 2'b01,
    CMD_RD_ADDR = 2'b10,
    CMD_RD_DATA = 2'b11
  } cmd_e;

endpackage

// File: rtl/spi_ram_array.sv
// Byte storage with a synchronous write port and a registered, enable-gated read port.
// Holds no reset; contents are undefined until written.
module spi_ram_array #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8
) (
  input  logic                 clk_i,
  input  logic                 we_i,
  input  logic [ADDR_SIZE-1:0] waddr_i,
  input  logic [7:0]           wdata_i,
  input  logic                 re_i,
  input  logic [ADDR_SIZE-1:0] raddr_i,
  output logic [7:0]           rdata_o
);

  logic [7:0] mem_q [MEM_DEPTH];
  logic [7:0] rdata_q;

  // Write and enable-gated read share one edge; rdata_q holds between reads.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/spi_ram.sv
// Command-driven byte memory behind the SPI slave: edge-detects rx_valid, decodes the
// opcode, maintains independent write/read pointers and returns read bytes with tx_valid.
module spi_ram
  import spi_ram_pkg::*;
#(
  parameter int MEM_DEPTH = DEF_MEM_DEPTH,
  parameter int ADDR_SIZE = DEF_ADDR_SIZE
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ADDR_SIZE+1:0] din,
  input  logic                 rx_valid,
  output logic [7:0]           dout,
  output logic                 tx_valid,
  output logic                 cmd_err
);

  logic                 rx_valid_q;
  logic                 accept_s;
  cmd_e                 op_s;
  logic [ADDR_SIZE-1:0] payload_s;
  logic [ADDR_SIZE-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_SIZE-1:0] rd_ptr_q, rd_ptr_d;
  logic                 wr_armed_q, wr_armed_d;
  logic                 rd_armed_q, rd_armed_d;
  logic                 tx_valid_q, tx_valid_d;
  logic                 cmd_err_q, cmd_err_d;
  logic                 loaded_q, loaded_d;
  logic                 mem_we_s, mem_re_s;
  logic [7:0]           rdata_s;

  assign accept_s  = rx_valid & ~rx_valid_q;
  assign op_s      = cmd_e'(din[ADDR_SIZE+1:ADDR_SIZE]);
  assign payload_s = din[ADDR_SIZE-1:0];

  // Decode one accepted command; everything holds when no rising edge of rx_valid is seen.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    wr_armed_d = wr_armed_q;
    rd_armed_d = rd_armed_q;
    tx_valid_d = tx_valid_q;
    loaded_d   = loaded_q;
    cmd_err_d  = 1'b0;
    mem_we_s   = 1'b0;
    mem_re_s   = 1'b0;
    if (accept_s) begin
      tx_valid_d = 1'b0;
      case (op_s)
        CMD_WR_ADDR: begin
          wr_ptr_d   = payload_s;
          wr_armed_d = 1'b1;
        end
        CMD_WR_DATA: begin
          if (wr_armed_q) begin
            mem_we_s = 1'b1;
            wr_ptr_d = wr_ptr_q + ADDR_SIZE'(1);
          end else begin
            cmd_err_d = 1'b1;
          end
        end
        CMD_RD_ADDR: begin
          rd_ptr_d   = payload_s;
          rd_armed_d = 1'b1;
        end
        CMD_RD_DATA: begin
          if (rd_armed_q) begin
            mem_re_s   = 1'b1;
            tx_valid_d = 1'b1;
            loaded_d   = 1'b1;
            rd_ptr_d   = rd_ptr_q + ADDR_SIZE'(1);
          end else begin
            cmd_err_d = 1'b1;
          end
        end
        default: begin
          cmd_err_d = 1'b1;
        end
      endcase
    end else begin
      cmd_err_d = 1'b0;
    end
  end

  // Control state; armed flags clear only here, so a reset also blocks any pending write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_valid_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      wr_armed_q <= 1'b0;
      rd_armed_q <= 1'b0;
      tx_valid_q <= 1'b0;
      cmd_err_q  <= 1'b0;
      loaded_q   <= 1'b0;
    end else begin
      rx_valid_q <= rx_valid;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_armed_q <= wr_armed_d;
      rd_armed_q <= rd_armed_d;
      tx_valid_q <= tx_valid_d;
      cmd_err_q  <= cmd_err_d;
      loaded_q   <= loaded_d;
    end
  end

  spi_ram_array #(
    .MEM_DEPTH (MEM_DEPTH),
    .ADDR_SIZE (ADDR_SIZE)
  ) u_array (
    .clk_i   (clk),
    .we_i    (mem_we_s),
    .waddr_i (wr_ptr_q),
    .wdata_i (din[7:0]),
    .re_i    (mem_re_s),
    .raddr_i (rd_ptr_q),
    .rdata_o (rdata_s)
  );

  // The array read register has no reset; loaded_q forces dout to zero until the first read.
  assign dout     = loaded_q ? rdata_s : 8'h00;
  assign tx_valid = tx_valid_q;
  assign cmd_err  = cmd_err_q;

endmodule

// File: tb/tb_spi_ram.sv
// Directed, table-driven bench for spi_ram plus hand sequences for hold, sticky output
// and mid-command reset behaviour.
module tb_spi_ram;
  import spi_ram_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] din;
  logic       rx_valid;
  logic [7:0] dout;
  logic       tx_valid;
  logic       cmd_err;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic [1:0] op;
    logic [7:0] pl;
    int         exp_err;
    logic       exp_tx;
    logic       chk_dout;
    logic [7:0] exp_dout;
  } vec_t;

  vec_t vecs[$];

  spi_ram dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .din      (din),
    .rx_valid (rx_valid),
    .dout     (dout),
    .tx_valid (tx_valid),
    .cmd_err  (cmd_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Raise rx_valid for 'hold' cycles (din scrambled after the first), then drop it.
  // Returns how many cycles cmd_err was seen high.
  task automatic send(input logic [1:0] op, input logic [7:0] pl, input int hold,
                      output int errs);
    errs = 0;
    @(negedge clk);
    din      = {op, pl};
    rx_valid = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (cmd_err === 1'b1) errs++;
      if (i == 0) din = ~din;
    end
    rx_valid = 1'b0;
    @(negedge clk);
    if (cmd_err === 1'b1) errs++;
  endtask

  task automatic cmd_check(input string name, input logic [1:0] op, input logic [7:0] pl,
                           input int hold, input int exp_err, input logic exp_tx,
                           input logic chk_dout, input logic [7:0] exp_dout);
    int e;
    send(op, pl, hold, e);
    check({name, " err"}, e, exp_err);
    check({name, " tx_valid"}, {31'd0, tx_valid}, {31'd0, exp_tx});
    if (chk_dout) check({name, " dout"}, {24'd0, dout}, {24'd0, exp_dout});
  endtask

  initial begin
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    din      = 10'd0;
    repeat (3) @(negedge clk);
    check("reset dout", {24'd0, dout}, 32'd0);
    check("reset tx_valid", {31'd0, tx_valid}, 32'd0);
    check("reset cmd_err", {31'd0, cmd_err}, 32'd0);
    rst_n = 1'b1;

    // op, payload, err pulses, tx_valid, check dout, dout
    vecs.push_back('{CMD_WR_DATA, 8'h55, 1, 1'b0, 1'b0, 8'h00});
    vecs.push_back('{CMD_RD_DATA, 8'h00, 1, 1'b0, 1'b1, 8'h00});
    vecs.push_back('{CMD_WR_ADDR, 8'h10, 0, 1'b0, 1'b0, 8'h00});
    vecs.push_back('{CMD_WR_DATA, 8'hA5, 0, 1'b0, 1'b0, 8'h00});
    vecs.push_back('{CMD_RD_ADDR, 8'h10, 0, 1'b0, 1'b0, 8'h00});
    vecs.push_back('{CMD_RD_DATA, 8'h00, 0, 1'b1, 1'b1, 8'hA5});
    vecs.push_back('{CMD_WR_ADDR, 8'hFE, 0, 1'b0, 1'b1, 8'hA5});
    vecs.push_back('{CMD_WR_DATA, 8'h11, 0, 1'b0, 1'b0, 8'h00});
    vecs.push_back('{CMD_WR_DATA, 8'h22, 0, 1'b0, 1'b0, 8'h00});
    vecs.push_back('{CMD_WR_DATA, 8'h33, 0, 1'b0, 1'b0, 8'h00});
    vecs.push_back('{CMD_WR_DATA, 8'h44, 0, 1'b0, 1'b0, 8'h00});
    vecs.push_back('{CMD_RD_ADDR, 8'hFE, 0, 1'b0, 1'b0, 8'h00});
    vecs.push_back('{CMD_RD_DATA, 8'h00, 0, 1'b1, 1'b1, 8'h11});
    vecs.push_back('{CMD_RD_DATA, 8'h00, 0, 1'b1, 1'b1, 8'h22});
    vecs.push_back('{CMD_RD_DATA, 8'h00, 0, 1'b1, 1'b1, 8'h33});
    vecs.push_back('{CMD_RD_DATA, 8'h00, 0, 1'b1, 1'b1, 8'h44});
    vecs.push_back('{CMD_RD_ADDR, 8'h10, 0, 1'b0, 1'b1, 8'h44});
    vecs.push_back('{CMD_RD_DATA, 8'h00, 0, 1'b1, 1'b1, 8'hA5});

    foreach (vecs[i]) begin
      cmd_check($sformatf("vec%0d", i), vecs[i].op, vecs[i].pl, 1, vecs[i].exp_err,
                vecs[i].exp_tx, vecs[i].chk_dout, vecs[i].exp_dout);
    end

    // rx_valid held 5 cycles: exactly one write, so the next write lands at 8'h21.
    cmd_check("hold wr_addr", CMD_WR_ADDR, 8'h20, 1, 0, 1'b0, 1'b0, 8'h00);
    cmd_check("hold wr_data", CMD_WR_DATA, 8'h77, 5, 0, 1'b0, 1'b0, 8'h00);
    cmd_check("hold wr_next", CMD_WR_DATA, 8'h88, 1, 0, 1'b0, 1'b0, 8'h00);
    cmd_check("hold rd_addr", CMD_RD_ADDR, 8'h20, 1, 0, 1'b0, 1'b0, 8'h00);
    cmd_check("hold rd20", CMD_RD_DATA, 8'h00, 1, 0, 1'b1, 1'b1, 8'h77);
    cmd_check("hold rd21", CMD_RD_DATA, 8'h00, 1, 0, 1'b1, 1'b1, 8'h88);

    // Sticky outputs across 10 idle cycles, then a non-read command clears tx_valid only.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("sticky tx%0d", i), {31'd0, tx_valid}, 32'd1);
      check($sformatf("sticky dout%0d", i), {24'd0, dout}, 32'h88);
    end
    cmd_check("sticky clear", CMD_WR_ADDR, 8'h30, 1, 0, 1'b0, 1'b1, 8'h88);

    // Reset during the acceptance cycle of a WR_DATA.
    cmd_check("rst wr30", CMD_WR_DATA, 8'hC3, 1, 0, 1'b0, 1'b0, 8'h00);
    cmd_check("rst rd_addr", CMD_RD_ADDR, 8'h30, 1, 0, 1'b0, 1'b0, 8'h00);
    cmd_check("rst wr_addr", CMD_WR_ADDR, 8'h30, 1, 0, 1'b0, 1'b0, 8'h00);
    cmd_check("rst rd30", CMD_RD_DATA, 8'h00, 1, 0, 1'b1, 1'b1, 8'hC3);
    @(negedge clk);
    din      = {CMD_WR_DATA, 8'h5A};
    rx_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("midrst dout", {24'd0, dout}, 32'd0);
    check("midrst tx_valid", {31'd0, tx_valid}, 32'd0);
    check("midrst cmd_err", {31'd0, cmd_err}, 32'd0);
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cmd_check("post wr_data", CMD_WR_DATA, 8'h66, 1, 1, 1'b0, 1'b1, 8'h00);
    cmd_check("post rd_data", CMD_RD_DATA, 8'h00, 1, 1, 1'b0, 1'b1, 8'h00);
    cmd_check("post rd_addr", CMD_RD_ADDR, 8'h30, 1, 0, 1'b0, 1'b0, 8'h00);
    cmd_check("post rd30", CMD_RD_DATA, 8'h00, 1, 0, 1'b1, 1'b1, 8'hC3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
